// File: rtl/fetch_stage_if.sv
// fetch_stage_if: imem bus, execute redirect and IF/ID outputs of the fetch stage.
// FETCH_PERF_EN adds the perf counter outputs.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall_d;
    logic        redirect_e;
    logic [31:0] redirect_pc_e;
    logic        valid_d;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic [6:0]  opcode_d;
    logic [2:0]  func3_d;
    logic [6:0]  func7_d;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_instr_cnt;
    logic [31:0] perf_redirect_cnt;
    modport master(
        input  imem_rdata, stall_d, redirect_e, redirect_pc_e,
        output imem_req, imem_addr, valid_d, instr_d, pc_d, pc_plus4_d,
               opcode_d, func3_d, func7_d, perf_instr_cnt, perf_redirect_cnt
    );
    modport slave(
        output imem_rdata, stall_d, redirect_e, redirect_pc_e,
        input  imem_req, imem_addr, valid_d, instr_d, pc_d, pc_plus4_d,
               opcode_d, func3_d, func7_d, perf_instr_cnt, perf_redirect_cnt
    );
`else
    modport master(
        input  imem_rdata, stall_d, redirect_e, redirect_pc_e,
        output imem_req, imem_addr, valid_d, instr_d, pc_d, pc_plus4_d,
               opcode_d, func3_d, func7_d
    );
    modport slave(
        output imem_rdata, stall_d, redirect_e, redirect_pc_e,
        input  imem_req, imem_addr, valid_d, instr_d, pc_d, pc_plus4_d,
               opcode_d, func3_d, func7_d
    );
`endif
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: RV32 PC generator, 1-cycle imem driver and stall-able IF/ID register with skid.
// FETCH_PERF_EN adds retired-instruction and redirect counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input logic           clk,
    input logic           rst,
    fetch_stage_if.master bus
);
    logic [31:0] pc_f, fetch_addr, inflight_pc, skid_instr, skid_pc, src_instr, src_pc;
    logic [31:0] instr_d, pc_d, pc_plus4_d;
    logic        inflight, skid_valid, valid_d;
    assign fetch_addr = bus.redirect_e ? (bus.redirect_pc_e & ~32'd3) : pc_f;
    assign bus.imem_req  = !rst & (bus.redirect_e | !bus.stall_d);
    assign bus.imem_addr = fetch_addr;
    // A held skid entry is always older than anything in flight
    assign src_instr = skid_valid ? skid_instr : bus.imem_rdata;
    assign src_pc    = skid_valid ? skid_pc : inflight_pc;
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f        <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            skid_valid  <= 1'b0;
            skid_instr  <= NOP_INSTR;
            skid_pc     <= '0;
            valid_d     <= 1'b0;
            instr_d     <= NOP_INSTR;
            pc_d        <= '0;
            pc_plus4_d  <= '0;
        end else begin
            inflight    <= bus.imem_req;
            inflight_pc <= fetch_addr;
            if (bus.imem_req) pc_f <= fetch_addr + 32'd4;
            if (bus.redirect_e) begin
                valid_d    <= 1'b0;
                instr_d    <= NOP_INSTR;
                skid_valid <= 1'b0;
            end else if (bus.stall_d) begin
                if (inflight) begin
                    skid_valid <= 1'b1;
                    skid_instr <= bus.imem_rdata;
                    skid_pc    <= inflight_pc;
                end
            end else if (skid_valid | inflight) begin
                valid_d    <= 1'b1;
                instr_d    <= src_instr;
                pc_d       <= src_pc;
                pc_plus4_d <= src_pc + 32'd4;
                skid_valid <= 1'b0;
            end else begin
                valid_d <= 1'b0;
                instr_d <= NOP_INSTR;
            end
        end
    end
    assign bus.valid_d    = valid_d;
    assign bus.instr_d    = instr_d;
    assign bus.pc_d       = pc_d;
    assign bus.pc_plus4_d = pc_plus4_d;
    assign bus.opcode_d   = instr_d[6:0];
    assign bus.func3_d    = instr_d[14:12];
    assign bus.func7_d    = instr_d[31:25];
`ifdef FETCH_PERF_EN
    logic [31:0] instr_cnt, redirect_cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            if (valid_d & !bus.stall_d & !bus.redirect_e) instr_cnt <= instr_cnt + 32'd1;
            if (bus.redirect_e) redirect_cnt <= redirect_cnt + 32'd1;
        end
    end
    assign bus.perf_instr_cnt    = instr_cnt;
    assign bus.perf_redirect_cnt = redirect_cnt;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed plus random stimulus; expected PC stream kept in a scoreboard queue.
module tb_fetch_stage;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] SALT = 32'hA5A5_0000;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    fetch_stage_if bus();
    fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (.clk(clk), .rst(rst), .bus(bus));
    int total = 0;
    int bad = 0;
    int accepts = 0;
    logic [31:0] exp_q[$];
    logic [31:0] fetch_pc, m_addr, m_pc, m_instr;
    logic        m_req;
`ifdef FETCH_PERF_EN
    logic [31:0] exp_icnt, exp_rcnt;
`endif
    always @(posedge clk) bus.imem_rdata <= bus.imem_req ? (bus.imem_addr ^ SALT) : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus: drive one cycle's inputs and push the expected stream restart
    task automatic step(input logic s, input logic r, input logic [31:0] t, input logic x);
        @(posedge clk);
        #1;
        rst = x;
        bus.stall_d = s;
        bus.redirect_e = r;
        bus.redirect_pc_e = t;
        if (x) begin
            exp_q.delete();
            exp_q.push_back(32'h0);
        end else if (r) begin
            exp_q.delete();
            exp_q.push_back(t & ~32'd3);
        end
    endtask

    task automatic tick(input logic s, input logic r, input logic [31:0] t);
        step(s, r, t, 1'b0);
        @(negedge clk);
    endtask

    task automatic restart();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic chk_v(input string name, input logic v, input logic [31:0] pc);
        chk({name, "_valid"}, 32'(bus.valid_d), 32'(v));
        if (v) chk({name, "_pc"}, bus.pc_d, pc);
    endtask

    // Monitor: checks fetch requests each cycle and pops the scoreboard on every accepted instruction
    always @(negedge clk) begin
        if (rst) begin
            fetch_pc = 32'h0;
            chk("req_in_rst", 32'(bus.imem_req), 32'h0);
`ifdef FETCH_PERF_EN
            exp_icnt = 0;
            exp_rcnt = 0;
`endif
        end else begin
            m_req = bus.redirect_e | !bus.stall_d;
            m_addr = bus.redirect_e ? (bus.redirect_pc_e & ~32'd3) : fetch_pc;
            chk("imem_req", 32'(bus.imem_req), 32'(m_req));
            if (m_req) begin
                chk("imem_addr", bus.imem_addr, m_addr);
                fetch_pc = m_addr + 32'd4;
            end
            total++;
            assert (!(dut.skid_valid & dut.inflight & !bus.stall_d)) else begin
                bad++;
                $display("FAIL skid_overflow: skid_valid=1 inflight=1 stall_d=0 at %0t", $time);
            end
`ifdef FETCH_PERF_EN
            chk("perf_instr", bus.perf_instr_cnt, exp_icnt);
            chk("perf_redirect", bus.perf_redirect_cnt, exp_rcnt);
            if (bus.redirect_e) exp_rcnt++;
            if (bus.valid_d & !bus.stall_d & !bus.redirect_e) exp_icnt++;
`endif
            if (bus.valid_d & !bus.stall_d & !bus.redirect_e) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_instr: got pc %h want none", bus.pc_d);
                end else begin
                    m_pc = exp_q.pop_front();
                    m_instr = m_pc ^ SALT;
                    chk("pc_d", bus.pc_d, m_pc);
                    chk("instr_d", bus.instr_d, m_instr);
                    chk("pc_plus4_d", bus.pc_plus4_d, m_pc + 32'd4);
                    chk("opcode_d", 32'(bus.opcode_d), 32'(m_instr[6:0]));
                    chk("func3_d", 32'(bus.func3_d), 32'(m_instr[14:12]));
                    chk("func7_d", 32'(bus.func7_d), 32'(m_instr[31:25]));
                    exp_q.push_back(m_pc + 32'd4);
                    accepts++;
                end
            end
        end
    end

    initial begin
        bus.stall_d = 1'b0;
        bus.redirect_e = 1'b0;
        bus.redirect_pc_e = 32'h0;
        // Cold start latency and stall with skid
        restart();
        tick(0, 0, 0);
        chk("rst_valid", 32'(bus.valid_d), 32'h0);
        chk("rst_instr", bus.instr_d, NOP);
        chk("rst_pc", bus.pc_d, 32'h0);
        tick(0, 0, 0);
        tick(0, 0, 0);
        chk_v("c2", 1, 32'h0);
        chk("c2_instr", bus.instr_d, 32'hA5A5_0000);
        chk("c2_func7", 32'(bus.func7_d), 32'h52);
        tick(0, 0, 0);
        chk_v("c3", 1, 32'h4);
        tick(0, 0, 0);
        chk_v("c4", 1, 32'h8);
        for (int i = 5; i < 8; i++) begin
            tick(1, 0, 0);
            chk("stall_req", 32'(bus.imem_req), 32'h0);
            chk_v("stall_hold", 1, 32'hC);
        end
        chk("skid_valid", 32'(dut.skid_valid), 32'h1);
        chk("skid_pc", dut.skid_pc, 32'h10);
        tick(0, 0, 0);
        chk_v("c8", 1, 32'hC);
        tick(0, 0, 0);
        chk_v("c9", 1, 32'h10);
        tick(0, 0, 0);
        chk_v("c10", 1, 32'h14);
        tick(0, 0, 0);
        chk_v("c11", 1, 32'h18);
        // Redirect without stall
        restart();
        for (int i = 0; i < 6; i++) tick(0, 0, 0);
        tick(0, 1, 32'h100);
        chk("redir_addr", bus.imem_addr, 32'h100);
        chk("redir_req", 32'(bus.imem_req), 32'h1);
        tick(0, 0, 0);
        chk_v("redir_bubble", 0, 0);
        tick(0, 0, 0);
        chk_v("redir_tgt", 1, 32'h100);
        chk("redir_pc4", bus.pc_plus4_d, 32'h104);
        tick(0, 0, 0);
        chk_v("redir_next", 1, 32'h104);
        // Redirect while stalled with a full skid
        restart();
        for (int i = 0; i < 5; i++) tick(0, 0, 0);
        tick(1, 0, 0);
        tick(1, 1, 32'h103);
        chk("sr_addr", bus.imem_addr, 32'h100);
        chk("sr_skid_before", 32'(dut.skid_valid), 32'h1);
        tick(1, 0, 0);
        chk_v("sr_flush", 0, 0);
        chk("sr_skid_cleared", 32'(dut.skid_valid), 32'h0);
        tick(0, 0, 0);
        chk_v("sr_drain", 0, 0);
        tick(0, 0, 0);
        chk_v("sr_tgt", 1, 32'h100);
        // Wrap at the top of the address space
        restart();
        for (int i = 0; i < 4; i++) tick(0, 0, 0);
        tick(0, 1, 32'hFFFF_FFFC);
        tick(0, 0, 0);
        chk_v("wrap_bubble", 0, 0);
        tick(0, 0, 0);
        chk_v("wrap_top", 1, 32'hFFFF_FFFC);
        chk("wrap_pc4", bus.pc_plus4_d, 32'h0);
        tick(0, 0, 0);
        chk_v("wrap_zero", 1, 32'h0);
        // Reset mid-operation with a full skid
        restart();
        for (int i = 0; i < 5; i++) tick(0, 0, 0);
        tick(1, 0, 0);
        step(1, 0, 0, 1);
        @(negedge clk);
        chk("mr_skid_before", 32'(dut.skid_valid), 32'h1);
        tick(0, 0, 0);
        chk_v("mr_c0", 0, 0);
        chk("mr_instr", bus.instr_d, NOP);
`ifdef FETCH_PERF_EN
        chk("mr_perf_instr", bus.perf_instr_cnt, 32'h0);
        chk("mr_perf_redir", bus.perf_redirect_cnt, 32'h0);
`endif
        tick(0, 0, 0);
        chk_v("mr_c1", 0, 0);
        tick(0, 0, 0);
        chk_v("mr_c2", 1, 32'h0);
        // Random traffic against the scoreboard
        accepts = 0;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                 ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom,
                 $urandom_range(0, 149) == 0);
        end
        for (int i = 0; i < 4; i++) tick(0, 0, 0);
        chk("liveness", 32'(accepts > 1000), 32'h1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
